// File: rtl/psel_rr.sv
// psel_rr: registered multi-channel priority selector (fixed or round-robin)
// Ports:
//   clock, reset_n   rising-edge clock, synchronous active-low reset
//   req              request vector, one bit per requester
//   mode_rr          1 = round-robin search from ptr downward, 0 = highest index wins
//   out_ready        downstream accepts the registered grant set
//   out_valid        registered grant set is valid
//   gnt_bus          one-hot grant per channel, channel k at [k*WIDTH +: WIDTH]
//   gnt_vld          per-channel grant-valid bits
//   gnt_all          OR of all channel grants
//   ptr              current round-robin search start index
//   grant_cnt        saturating count of granted channels over all transfers
//                    (present only when PSEL_RR_PERF_EN is defined)
module psel_rr #(
  parameter int WIDTH = 16,
  parameter int NUM_GNT = 2,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         req,
  input  logic                     mode_rr,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [NUM_GNT*WIDTH-1:0] gnt_bus,
  output logic [NUM_GNT-1:0]       gnt_vld,
  output logic [WIDTH-1:0]         gnt_all,
  output logic [IDX_W-1:0]         ptr
`ifdef PSEL_RR_PERF_EN
  ,
  output logic [31:0]              grant_cnt
`endif
);
  logic                             out_valid_q;
  logic [NUM_GNT-1:0][WIDTH-1:0]    gnt_q, gnt_d;
  logic [NUM_GNT-1:0]               vld_q, vld_d;
  logic [IDX_W-1:0]                 ptr_q, ptr_d, last_idx, srch;
  logic [WIDTH-1:0]                 all_q, cand;
  logic                             xfer, load;
  int                               nfound, pos;

  assign xfer = out_valid_q & out_ready;
  assign load = ~out_valid_q | out_ready;
  // requesters just handed off are masked so nobody is granted twice in a row
  assign cand = xfer ? (req & ~all_q) : req;

  always_comb begin
    all_q = '0;
    for (int k = 0; k < NUM_GNT; k++) all_q |= gnt_q[k];
  end

  // index granted on the highest valid channel, i.e. the last one found in search order
  always_comb begin
    last_idx = '0;
    for (int k = 0; k < NUM_GNT; k++)
      for (int i = 0; i < WIDTH; i++)
        if (vld_q[k] && gnt_q[k][i]) last_idx = IDX_W'(i);
  end

  assign ptr_d = (xfer && mode_rr) ? ((last_idx == '0) ? IDX_W'(WIDTH-1) : last_idx - 1'b1) : ptr_q;
  // fixed priority is the same downward search, always starting at the top
  assign srch = mode_rr ? ptr_d : IDX_W'(WIDTH-1);

  always_comb begin
    gnt_d = '0;
    vld_d = '0;
    nfound = 0;
    pos = 0;
    for (int i = 0; i < WIDTH; i++) begin
      pos = (int'(srch) - i + WIDTH) % WIDTH;
      if (cand[pos[IDX_W-1:0]]) begin
        for (int k = 0; k < NUM_GNT; k++)
          if (nfound == k) begin
            gnt_d[k][pos[IDX_W-1:0]] = 1'b1;
            vld_d[k] = 1'b1;
          end
        nfound = nfound + 1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      gnt_q <= '0;
      vld_q <= '0;
      ptr_q <= IDX_W'(WIDTH-1);
    end else if (load) begin
      out_valid_q <= |cand;
      gnt_q <= gnt_d;
      vld_q <= vld_d;
      ptr_q <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign gnt_bus = gnt_q;
  assign gnt_vld = vld_q;
  assign gnt_all = all_q;
  assign ptr = ptr_q;

`ifdef PSEL_RR_PERF_EN
  logic [31:0] cnt_q;
  logic [32:0] cnt_sum;
  assign cnt_sum = {1'b0, cnt_q} + 33'($countones(vld_q));
  always_ff @(posedge clock) begin
    if (!reset_n) cnt_q <= '0;
    else if (xfer) cnt_q <= cnt_sum[32] ? '1 : cnt_sum[31:0];
  end
  assign grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_psel_rr.sv
// tb_psel_rr: directed self-checking bench for psel_rr (WIDTH=8, NUM_GNT=2)
module tb_psel_rr;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  req = '0;
  logic        mode_rr = 1'b0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [15:0] gnt_bus;
  logic [1:0]  gnt_vld;
  logic [7:0]  gnt_all;
  logic [2:0]  ptr;
`ifdef PSEL_RR_PERF_EN
  logic [31:0] grant_cnt;
`endif
  int n_chk = 0;
  int n_pass = 0;

  psel_rr #(.WIDTH(8), .NUM_GNT(2)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .mode_rr(mode_rr),
    .out_ready(out_ready), .out_valid(out_valid), .gnt_bus(gnt_bus),
    .gnt_vld(gnt_vld), .gnt_all(gnt_all), .ptr(ptr)
`ifdef PSEL_RR_PERF_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [15:0] rr_bus [5] = '{16'h4080, 16'h1020, 16'h0408, 16'h0102, 16'h4080};
  logic [2:0]  rr_ptr [5] = '{3'd7, 3'd5, 3'd3, 3'd1, 3'd7};
  logic [7:0]  stall_req [3] = '{8'h01, 8'h02, 8'h03};

  initial begin
    step();
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ptr", 32'(ptr), 32'd7);
    check("rst_bus", 32'(gnt_bus), 32'd0);
    check("rst_vld", 32'(gnt_vld), 32'd0);
    reset_n = 1'b1;
    req = 8'hA6;
    step();
    check("fix_bus", 32'(gnt_bus), 32'h2080);
    check("fix_vld", 32'(gnt_vld), 32'd3);
    check("fix_all", 32'(gnt_all), 32'hA0);
    check("fix_valid", 32'(out_valid), 32'd1);
    req = 8'h00;
    step();
    check("fix_empty_valid", 32'(out_valid), 32'd0);
    check("fix_empty_bus", 32'(gnt_bus), 32'd0);
    req = 8'h03;
    step();
    check("fix_low_bus", 32'(gnt_bus), 32'h0102);
    check("fix_low_ptr", 32'(ptr), 32'd7);
    step();
    check("no_back2back", 32'(out_valid), 32'd0);
    mode_rr = 1'b1;
    req = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rr_bus%0d", i), 32'(gnt_bus), 32'(rr_bus[i]));
      check($sformatf("rr_ptr%0d", i), 32'(ptr), 32'(rr_ptr[i]));
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req = stall_req[i];
      step();
      check($sformatf("stall_bus%0d", i), 32'(gnt_bus), 32'h4080);
      check($sformatf("stall_vld%0d", i), 32'(gnt_vld), 32'd3);
      check($sformatf("stall_ptr%0d", i), 32'(ptr), 32'd7);
      check($sformatf("stall_valid%0d", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    req = 8'hFF;
    step();
    check("release_bus", 32'(gnt_bus), 32'h1020);
    check("release_ptr", 32'(ptr), 32'd5);
    req = 8'h04;
    step();
    check("single_bus", 32'(gnt_bus), 32'h0004);
    check("single_vld", 32'(gnt_vld), 32'd1);
    check("single_ptr", 32'(ptr), 32'd3);
    req = 8'h00;
    step();
    check("drain_valid", 32'(out_valid), 32'd0);
    req = 8'hFF;
    step();
    check("pre_stall_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    check("rst_stall_valid", 32'(out_valid), 32'd0);
    check("rst_stall_ptr", 32'(ptr), 32'd7);
    check("rst_stall_bus", 32'(gnt_bus), 32'd0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    mode_rr = 1'b0;
`ifdef PSEL_RR_PERF_EN
    req = 8'hC0;
    step();
    req = 8'h08;
    step();
    req = 8'h30;
    step();
    req = 8'h00;
    step();
    check("perf_cnt", grant_cnt, 32'd5);
    req = 8'hC0;
    step();
    dut.cnt_q = 32'hFFFFFFFE;
    req = 8'h30;
    step();
    check("perf_sat", grant_cnt, 32'hFFFFFFFF);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
